// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_pkg -- ALU operation codes, RV opcodes, result-select codes  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package alu_pkg;

  localparam logic [5:0] c_ALU_ADD = 6'b000000;
  localparam logic [5:0] c_ALU_SUB = 6'b000001;
  localparam logic [5:0] c_ALU_AND = 6'b100000;
  localparam logic [5:0] c_ALU_OR  = 6'b100001;
  localparam logic [5:0] c_ALU_XOR = 6'b100011;
  localparam logic [5:0] c_ALU_SLL = 6'b110011;
  localparam logic [5:0] c_ALU_SRL = 6'b110010;
  localparam logic [5:0] c_ALU_SRA = 6'b110000;

  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    CMP_ALU    = 2'b00,
    CMP_SLT    = 2'b01,
    CMP_SLTU   = 2'b10,
    CMP_BRANCH = 2'b11
  } cmp_sel_e;

endpackage
`default_nettype wire

// File: rtl/alu_op_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_op_decoder -- RV64I opcode/funct decode into ALU operands/op |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module alu_op_decoder
  import alu_pkg::*;
#(
  parameter int WORDSIZE = 64,
  parameter int SHAMT_W  = 6
) (
  input  logic [6:0]          i_opcode,
  input  logic [2:0]          i_funct3,
  input  logic                i_funct7b5,
  input  logic [WORDSIZE-1:0] i_rs1,
  input  logic [WORDSIZE-1:0] i_rs2,
  input  logic [WORDSIZE-1:0] i_imm,
  input  logic [WORDSIZE-1:0] i_pc,
  output logic [WORDSIZE-1:0] o_a,
  output logic [WORDSIZE-1:0] o_b,
  output logic [5:0]          o_op,
  output logic [1:0]          o_cmp,
  output logic                o_illegal
);

  logic [WORDSIZE-1:0] w_src2;
  logic [WORDSIZE-1:0] w_shamt;

  assign w_src2  = (i_opcode == c_OPC_OP) ? i_rs2 : i_imm;
  assign w_shamt = {{(WORDSIZE-SHAMT_W){1'b0}}, w_src2[SHAMT_W-1:0]};

  always_comb begin
    o_a       = '0;
    o_b       = '0;
    o_op      = c_ALU_ADD;
    o_cmp     = CMP_ALU;
    o_illegal = 1'b0;
    case (i_opcode)
      c_OPC_OP, c_OPC_OP_IMM: begin
        o_a = i_rs1;
        o_b = w_src2;
        case (i_funct3)
          3'b000: o_op = (i_opcode == c_OPC_OP && i_funct7b5) ? c_ALU_SUB : c_ALU_ADD;
          3'b001: begin o_op = c_ALU_SLL; o_b = w_shamt; end
          3'b010: begin o_op = c_ALU_SUB; o_cmp = CMP_SLT; end
          3'b011: begin o_op = c_ALU_SUB; o_cmp = CMP_SLTU; end
          3'b100: o_op = c_ALU_XOR;
          3'b101: begin o_op = i_funct7b5 ? c_ALU_SRA : c_ALU_SRL; o_b = w_shamt; end
          3'b110: o_op = c_ALU_OR;
          default: o_op = c_ALU_AND;
        endcase
      end
      c_OPC_LUI: o_b = i_imm;
      c_OPC_AUIPC: begin o_a = i_pc; o_b = i_imm; end
      // Loads: LB..LWU exist in RV64I, funct3=111 does not
      c_OPC_LOAD:
        if (i_funct3 != 3'b111) begin o_a = i_rs1; o_b = i_imm; end
        else o_illegal = 1'b1;
      c_OPC_STORE:
        if (!i_funct3[2]) begin o_a = i_rs1; o_b = i_imm; end
        else o_illegal = 1'b1;
      c_OPC_BRANCH:
        if (i_funct3[2:1] != 2'b01) begin
          o_a   = i_rs1;
          o_b   = i_rs2;
          o_op  = c_ALU_SUB;
          o_cmp = CMP_BRANCH;
        end else o_illegal = 1'b1;
      c_OPC_JAL: begin o_a = i_pc; o_b = WORDSIZE'(4); end
      c_OPC_JALR:
        if (i_funct3 == 3'b000) begin o_a = i_pc; o_b = WORDSIZE'(4); end
        else o_illegal = 1'b1;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_issue_stage -- ALU operand select with 2-entry skid buffer   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WORDSIZE = 64,
  parameter int SHAMT_W  = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [6:0]          in_opcode,
  input  logic [2:0]          in_funct3,
  input  logic                in_funct7b5,
  input  logic [4:0]          in_rd,
  input  logic [WORDSIZE-1:0] in_rs1_val,
  input  logic [WORDSIZE-1:0] in_rs2_val,
  input  logic [WORDSIZE-1:0] in_imm,
  input  logic [WORDSIZE-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDSIZE-1:0] out_a,
  output logic [WORDSIZE-1:0] out_b,
  output logic [5:0]          out_op,
  output logic [1:0]          out_cmp,
  output logic [2:0]          out_funct3,
  output logic [4:0]          out_rd,
  output logic                out_illegal
);

  localparam int c_PW = 2*WORDSIZE + 6 + 2 + 3 + 5 + 1;

  logic [WORDSIZE-1:0] w_dec_a;
  logic [WORDSIZE-1:0] w_dec_b;
  logic [5:0]          w_dec_op;
  logic [1:0]          w_dec_cmp;
  logic                w_dec_ill;
  logic [c_PW-1:0]     w_in_pl;
  logic                w_accept;
  logic                w_main_free;

  logic [c_PW-1:0]     r_main_pl;
  logic [c_PW-1:0]     r_skid_pl;
  logic                r_main_v;
  logic                r_skid_v;

  alu_op_decoder #(
    .WORDSIZE (WORDSIZE),
    .SHAMT_W  (SHAMT_W)
  ) u_dec (
    .i_opcode   (in_opcode),
    .i_funct3   (in_funct3),
    .i_funct7b5 (in_funct7b5),
    .i_rs1      (in_rs1_val),
    .i_rs2      (in_rs2_val),
    .i_imm      (in_imm),
    .i_pc       (in_pc),
    .o_a        (w_dec_a),
    .o_b        (w_dec_b),
    .o_op       (w_dec_op),
    .o_cmp      (w_dec_cmp),
    .o_illegal  (w_dec_ill)
  );

  assign w_in_pl     = {w_dec_a, w_dec_b, w_dec_op, w_dec_cmp, in_funct3, in_rd, w_dec_ill};
  assign w_accept    = in_valid & in_ready & ~flush;
  assign w_main_free = ~r_main_v | out_ready;

  // in_ready comes straight from a flop, so out_ready never reaches it combinationally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_main_v  <= 1'b0;
      r_skid_v  <= 1'b0;
      r_main_pl <= '0;
      r_skid_pl <= '0;
    end else if (flush) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_v) begin
        r_main_pl <= r_skid_pl;
        r_main_v  <= 1'b1;
        r_skid_v  <= 1'b0;
      end else begin
        r_main_v <= w_accept;
        if (w_accept) r_main_pl <= w_in_pl;
      end
    end else if (w_accept) begin
      r_skid_pl <= w_in_pl;
      r_skid_v  <= 1'b1;
    end
  end

  assign in_ready  = ~r_skid_v;
  assign out_valid = r_main_v;
  assign {out_a, out_b, out_op, out_cmp, out_funct3, out_rd, out_illegal} = r_main_pl;

endmodule
`default_nettype wire

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Execute-entry pipeline stage directly upstream of the ALU.
- Accepts a decoded RV64I instruction bundle with operand values and selects the ALU operands.
- Translates opcode/funct3/funct7 into the ALU's 6-bit operation code.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so full throughput holds under back-pressure.

Parameters:
- WORDSIZE, 64, datapath width; must match the ALU's WORDSIZE.
- SHAMT_W, 6, number of low operand-B bits kept for shift operations (log2 WORDSIZE).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous; discards all buffered entries.
- in_valid  in  1  input bundle valid.
- in_ready  out  1  stage can accept the bundle.
- in_opcode  in  7  instruction[6:0].
- in_funct3  in  3  instruction[14:12].
- in_funct7b5  in  1  instruction[30].
- in_rd  in  5  destination register index.
- in_rs1_val  in  WORDSIZE  rs1 value.
- in_rs2_val  in  WORDSIZE  rs2 value.
- in_imm  in  WORDSIZE  sign-extended immediate.
- in_pc  in  WORDSIZE  instruction address.
- out_valid  out  1  ALU bundle valid.
- out_ready  in  1  consumer accepts the bundle.
- out_a  out  WORDSIZE  ALU input_a.
- out_b  out  WORDSIZE  ALU input_b.
- out_op  out  6  ALU operation.
- out_cmp  out  2  result select: 00 = ALU result, 01 = SLT (flag_less), 10 = SLTU (flag_u_less), 11 = branch compare.
- out_funct3  out  3  funct3 passthrough, used for branch condition selection.
- out_rd  out  5  destination index passthrough.
- out_illegal  out  1  unsupported encoding.

Behaviour:
- Clocking and reset: one clock, clk. Reset is rst_n, synchronous and active-low.
  - While rst_n is low at an edge, both buffer entries are invalidated.
  - Reset values: out_valid=0, out_illegal=0, out_cmp=00. in_ready is 1 from the first edge after reset onward. Payload outputs are 0.
- Decode (combinational, before the register):
  - OP (0110011):
    - ADD→000000, SUB (f7b5=1)→000001.
    - AND→100000, OR→100001, XOR→100011.
    - SLL→110011, SRL→110010, SRA (f7b5=1)→110000.
    - SLT→000001 with cmp=01; SLTU→000001 with cmp=10.
    - a=rs1, b=rs2.
  - OP-IMM (0010011): same mapping with b=imm. The SUB bit is ignored. For shifts, f7b5 selects SRA.
  - LUI (0110111): a=0, b=imm, op=000000.
  - AUIPC (0010111): a=pc, b=imm, op=000000.
  - LOAD (0000011), STORE (0100011): a=rs1, b=imm, op=000000 (address generation).
  - BRANCH (1100011): a=rs1, b=rs2, op=000001, cmp=11.
  - JAL/JALR: a=pc, b=4, op=000000 (link value).
  - Shifts: b is zero-extended from its low SHAMT_W bits.
  - Any other opcode or funct3 combination: illegal=1, op=000000, a=b=0. The entry is still issued in order.
- Handshake:
  - Input transfer occurs on in_valid & in_ready.
  - Output transfer occurs on out_valid & out_ready.
  - Latency from accept to out_valid is 1 cycle.
  - in_ready = !skid_valid and is registered (no combinational path from out_ready).
  - While out_valid & !out_ready, every out_* signal is held stable.
- Buffering:
  - Main register drives the outputs. The skid register captures one accepted bundle when the main register is stalled.
  - When the main register drains, the skid entry moves to main in the same edge.
  - Order is preserved; nothing is dropped or duplicated.
- Simultaneous events:
  - Accept and drain in the same cycle with the skid entry empty: the new bundle replaces main, out_valid stays 1.
  - flush=1: both entries are invalidated at the edge and any input presented that cycle is not accepted. flush has priority over acceptance. in_ready=1 the next cycle.
  - Reset has priority over flush.
- Arithmetic: no arithmetic in this stage; operands are passed as WORDSIZE-bit values. OP-32/OP-IMM-32 are illegal here.

Decomposition:
- Package alu_pkg holds:
  - the 6-bit ALU operation localparams (shared with the ALU);
  - RV opcode constants;
  - the cmp-select encodings.
- Sub-module alu_op_decoder: purely combinational decode of opcode/funct3/f7b5/operands into a, b, op, cmp, illegal.
- The top module holds the main and skid registers and the handshake logic.

Test Plan:
- ADD x3 with rs1=5, rs2=7, out_ready=1: one cycle later out_op=000000, a=5, b=7, out_cmp=00, out_valid=1.
- SRAI with imm=0x43F, f7b5=1: out_op=110000, out_b=0x3F.
- SLTU: out_op=000001, out_cmp=10.
- AUIPC with pc=0x1000, imm=0x2000: out_a=0x1000, out_b=0x2000, out_op=000000.
- Back-to-back stream of 4 bundles with out_ready held low for 3 cycles after the first: the first is held stable, in_ready drops after the second is accepted, and all 4 emerge in order with no loss.
- flush asserted with both entries full and in_valid=1: next cycle out_valid=0, in_ready=1, and the presented bundle never appears at the output.
- Opcode 1111111: out_illegal=1, out_op=000000. rst_n held low mid-stream: out_valid=0 at the following edge.
